decode_out_packer: RTL and testbench

Downstream stage of the Viterbi decoder top. Consumes the serial decoded bit stream (`DecodeOut` plus a per-bit strobe) and discards the traceback flush bits at the start of each burst. Packs the remaining bits MSB-first into words and buffers them in a small first-word-fall-through FIFO. Presents the words to the host side over a valid/ready handshake.

---
 rtl/decode_out_packer.sv | 111 +++++++++++
 tb/tb_decode_out_packer.sv | 136 +++++++++++++
 2 files changed

// File: rtl/decode_out_packer.sv
// decode_out_packer: drops the traceback flush bits of each burst, packs the rest MSB-first into a FWFT FIFO.
// Optional `DESCRAMBLE_EN` XORs packed bits with an x^7+x^6+1 LFSR key stream.
module decode_out_packer #(
   parameter int WORD_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int SKIP_BITS  = 20
) (
   input  logic              CLOCK,
   input  logic              Reset,
   input  logic              Active,
   input  logic              BitStrobe,
   input  logic              DecodeOut,
   output logic [WORD_W-1:0] OutData,
   output logic              OutValid,
   input  logic              OutReady,
   output logic              Overflow,
   output logic [15:0]       WordCount
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int BW = $clog2(WORD_W);
   localparam int SW = SKIP_BITS < 2 ? 1 : $clog2(SKIP_BITS);
   localparam logic [SW-1:0] SKIP_LAST = SW'(SKIP_BITS > 0 ? SKIP_BITS - 1 : 0);
   localparam logic [BW-1:0] BIT_LAST = BW'(WORD_W - 1);
   localparam logic [1:0] IDLE = 2'd0, SKIP = 2'd1, PACK = 2'd2;

   logic [1:0]        state_q, state_d;
   logic [SW-1:0]     skip_q, skip_d;
   logic [BW-1:0]     bit_q, bit_d;
   logic [WORD_W-2:0] shreg_q, shreg_d;
   logic [WORD_W-1:0] word;
   logic              bit_in, push;
   logic [AW:0]       wr_q, rd_q;
   logic [WORD_W-1:0] mem_q [FIFO_DEPTH];
   logic              empty, full, pop, wr_en, drop;
   logic              overflow_q;
   logic [15:0]       count_q;

`ifdef DESCRAMBLE_EN
   logic [6:0] lfsr_q, lfsr_d;
   logic       key;
   assign key    = lfsr_q[6] ^ lfsr_q[5];
   assign bit_in = DecodeOut ^ key;
   // Reseed on every entry to PACK so each burst starts from the same key stream.
   assign lfsr_d = (state_q != PACK && state_d == PACK) ? 7'h7F :
                   (state_q == PACK && Active && BitStrobe) ? {lfsr_q[5:0], key} : lfsr_q;
   always_ff @(posedge CLOCK)
      if (!Reset) lfsr_q <= 7'h7F;
      else lfsr_q <= lfsr_d;
`else
   assign bit_in = DecodeOut;
`endif

   assign word = {shreg_q, bit_in};

   always_comb begin
      state_d = state_q;
      skip_d  = skip_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      push    = 1'b0;
      if (state_q == IDLE || !Active) begin
         skip_d  = '0;
         bit_d   = '0;
         shreg_d = '0;
         state_d = !Active ? IDLE : (SKIP_BITS == 0) ? PACK : SKIP;
      end else if (BitStrobe && state_q == SKIP) begin
         skip_d  = skip_q == SKIP_LAST ? '0 : skip_q + 1'b1;
         state_d = skip_q == SKIP_LAST ? PACK : SKIP;
      end else if (BitStrobe && state_q == PACK) begin
         shreg_d = word[WORD_W-2:0];
         push    = bit_q == BIT_LAST;
         bit_d   = push ? '0 : bit_q + 1'b1;
      end
   end

   // Extra pointer MSB distinguishes full from empty.
   assign empty = wr_q == rd_q;
   assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
   assign pop   = !empty && OutReady;
   assign wr_en = push && (!full || pop);
   assign drop  = push && full && !pop;

   always_ff @(posedge CLOCK)
      if (!Reset) begin
         state_q    <= IDLE;
         skip_q     <= '0;
         bit_q      <= '0;
         shreg_q    <= '0;
         wr_q       <= '0;
         rd_q       <= '0;
         overflow_q <= 1'b0;
         count_q    <= '0;
      end else begin
         state_q <= state_d;
         skip_q  <= skip_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         if (wr_en) wr_q <= wr_q + 1'b1;
         if (pop) rd_q <= rd_q + 1'b1;
         if (drop) overflow_q <= 1'b1;
         if (wr_en) count_q <= count_q + 16'd1;
      end

   always_ff @(posedge CLOCK)
      if (wr_en) mem_q[wr_q[AW-1:0]] <= word;

   assign OutData   = mem_q[rd_q[AW-1:0]];
   assign OutValid  = !empty;
   assign Overflow  = overflow_q;
   assign WordCount = count_q;
endmodule

// File: tb/tb_decode_out_packer.sv
// tb_decode_out_packer: directed vectors with hand-computed words for decode_out_packer (defaults 8/4/20).
module tb_decode_out_packer;
   logic       CLOCK = 1'b0;
   logic       Reset, Active, BitStrobe, DecodeOut, OutReady;
   logic [7:0] OutData;
   logic       OutValid, Overflow;
   logic [15:0] WordCount;
   int checks = 0, failures = 0;

   decode_out_packer dut (
      .CLOCK(CLOCK), .Reset(Reset), .Active(Active), .BitStrobe(BitStrobe),
      .DecodeOut(DecodeOut), .OutData(OutData), .OutValid(OutValid),
      .OutReady(OutReady), .Overflow(Overflow), .WordCount(WordCount)
   );

   always #5 CLOCK = ~CLOCK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLOCK);
      #1;
   endtask

   task automatic strobe(input logic b);
      BitStrobe = 1'b1;
      DecodeOut = b;
      tick();
      BitStrobe = 1'b0;
      DecodeOut = 1'b0;
   endtask

   task automatic send_word(input logic [7:0] w);
      for (int i = 7; i >= 0; i--) strobe(w[i]);
   endtask

   task automatic skip_junk();
      for (int i = 0; i < 20; i++) strobe(i[0]);
   endtask

   task automatic drain(input logic [7:0] w);
      check("drain_valid", {31'd0, OutValid}, 32'd1);
      check("drain_data", {24'd0, OutData}, {24'd0, w});
      OutReady = 1'b1;
      tick();
      OutReady = 1'b0;
   endtask

   initial begin
      Reset = 1'b0; Active = 1'b1; BitStrobe = 1'b1; DecodeOut = 1'b1; OutReady = 1'b0;
      repeat (3) tick();
      check("rst_valid", {31'd0, OutValid}, 32'd0);
      check("rst_overflow", {31'd0, Overflow}, 32'd0);
      check("rst_count", {16'd0, WordCount}, 32'd0);
      // First cycle after release sits in IDLE; its strobe must not count as a skip.
      Reset = 1'b1;
      tick();
      BitStrobe = 1'b0;
      skip_junk();
`ifdef DESCRAMBLE_EN
      for (int i = 0; i < 16; i++) strobe(1'b0);
      drain(8'h02);
      drain(8'h0C);
      check("desc_empty", {31'd0, OutValid}, 32'd0);
      Active = 1'b0;
      tick();
      Active = 1'b1;
      tick();
      skip_junk();
      for (int i = 0; i < 8; i++) strobe(1'b0);
      drain(8'h02);
      check("desc_count", {16'd0, WordCount}, 32'd3);
`else
      for (int i = 7; i >= 1; i--) strobe(8'hA5 >> i);
      check("a5_not_yet", {31'd0, OutValid}, 32'd0);
      strobe(1'b1);
      check("a5_count", {16'd0, WordCount}, 32'd1);
      drain(8'hA5);
      check("a5_single", {31'd0, OutValid}, 32'd0);
      // Four back-to-back words held with OutReady low, then drained one per cycle.
      for (int k = 1; k <= 4; k++) send_word(8'(k));
      check("b2b_count", {16'd0, WordCount}, 32'd5);
      check("b2b_overflow", {31'd0, Overflow}, 32'd0);
      OutReady = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         check("b2b_valid", {31'd0, OutValid}, 32'd1);
         check("b2b_data", {24'd0, OutData}, 32'(k));
         tick();
      end
      OutReady = 1'b0;
      check("b2b_empty", {31'd0, OutValid}, 32'd0);
      for (int k = 0; k < 5; k++) send_word(8'h10 + 8'(k));
      check("ovf_set", {31'd0, Overflow}, 32'd1);
      check("ovf_count", {16'd0, WordCount}, 32'd9);
      for (int k = 0; k < 4; k++) drain(8'h10 + 8'(k));
      check("ovf_empty", {31'd0, OutValid}, 32'd0);
      check("ovf_sticky", {31'd0, Overflow}, 32'd1);
      Reset = 1'b0;
      tick();
      check("rerst_overflow", {31'd0, Overflow}, 32'd0);
      check("rerst_count", {16'd0, WordCount}, 32'd0);
      Reset = 1'b1;
      tick();
      skip_junk();
      for (int k = 0; k < 4; k++) send_word(8'h20 + 8'(k));
      for (int i = 7; i >= 1; i--) strobe(8'h24 >> i);
      OutReady = 1'b1;
      strobe(1'b0);
      OutReady = 1'b0;
      check("full_pp_overflow", {31'd0, Overflow}, 32'd0);
      check("full_pp_count", {16'd0, WordCount}, 32'd5);
      for (int k = 1; k <= 4; k++) drain(8'h20 + 8'(k));
      check("full_pp_empty", {31'd0, OutValid}, 32'd0);
      // Abort after 5 packed bits; the abort-cycle strobe is ignored too.
      for (int i = 0; i < 5; i++) strobe(1'b1);
      Active = 1'b0;
      strobe(1'b1);
      check("abort_empty", {31'd0, OutValid}, 32'd0);
      Active = 1'b1;
      tick();
      skip_junk();
      send_word(8'hC3);
      check("abort_count", {16'd0, WordCount}, 32'd6);
      drain(8'hC3);
      check("abort_single", {31'd0, OutValid}, 32'd0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
